// File: rtl/tnn_seq_classifier.sv
// tnn_seq_classifier
//   Time-multiplexed ternary neural network classifier. One hidden layer of
//   threshold neurons is evaluated LANES at a time and accumulated into
//   per-class popcounts. The argmax over biased scores then runs one class per
//   cycle. All weights and biases are elaboration-time parameters.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   features valid
//   in_ready   out  idle, features accepted this cycle if in_valid
//   features   in   packed features, feature 0 in the MSBs
//   out_valid  out  prediction valid, held until out_ready
//   out_ready  in   consumer takes the prediction
//   prediction out  winning class index (lowest index wins ties)
//   margin     out  best minus second-best score
//
// Build option
//   TNN_SEQ_MARGIN_EN: track the second-best score and drive margin.
//   Undefined: no second-best tracking, margin tied to 0.
module tnn_seq_classifier #(
   parameter int unsigned FEAT_CNT   = 11,
   parameter int unsigned FEAT_BITS  = 4,
   parameter int unsigned HIDDEN_CNT = 40,
   parameter int unsigned CLASS_CNT  = 7,
   parameter int unsigned LANES      = 8,
   parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  W1_POS   = '0,
   parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  W1_NEG   = '0,
   parameter logic [HIDDEN_CNT-1:0]           H_FORCE0 = '0,
   parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2_POS   = '0,
   parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2_NEG   = '0,
   parameter logic [CLASS_CNT*($clog2(HIDDEN_CNT+1)+1)-1:0] BIAS = '0
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [FEAT_CNT*FEAT_BITS-1:0]       features,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [$clog2(CLASS_CNT)-1:0]        prediction,
   output logic [$clog2(HIDDEN_CNT+1):0]       margin
);

   localparam int unsigned SUM_BITS   = $clog2(HIDDEN_CNT + 1);
   localparam int unsigned SCORE_BITS = SUM_BITS + 1;
   localparam int unsigned RAW_BITS   = SCORE_BITS + 1;
   localparam int unsigned INDEX_BITS = $clog2(FEAT_CNT + 1) + FEAT_BITS;
   localparam int unsigned H_STEPS    = (HIDDEN_CNT + LANES - 1) / LANES;
   localparam int unsigned PRED_BITS  = $clog2(CLASS_CNT);
   localparam int unsigned CNT_MAX    = (H_STEPS > CLASS_CNT) ? H_STEPS : CLASS_CNT;
   localparam int unsigned CNT_BITS   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned W1_IW      = $clog2(HIDDEN_CNT * FEAT_CNT);
   localparam int unsigned W2_IW      = $clog2(CLASS_CNT * HIDDEN_CNT);
   localparam int unsigned H_IW       = (HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1;
   localparam int unsigned B_IW       = $clog2(CLASS_CNT * SCORE_BITS);

   typedef enum logic [1:0] {StIdle, StHidden, StArgmax, StDone} state_e;

   state_e                          state_q, state_d;
   logic [CNT_BITS-1:0]             cnt_q, cnt_d;
   logic [FEAT_CNT*FEAT_BITS-1:0]   feat_q, feat_d;
   logic [SUM_BITS-1:0]             pop_q [CLASS_CNT];
   logic [SUM_BITS-1:0]             pop_d [CLASS_CNT];
   logic [SCORE_BITS-1:0]           best_q, best_d;
   logic [PRED_BITS-1:0]            idx_q, idx_d;
   logic [PRED_BITS-1:0]            pred_q, pred_d;
   logic                            in_ready_q, in_ready_d;
   logic                            out_valid_q, out_valid_d;
`ifdef TNN_SEQ_MARGIN_EN
   logic [SCORE_BITS-1:0]           second_q, second_d, cand_second;
   logic [SCORE_BITS-1:0]           margin_q, margin_d;
`endif

   logic [FEAT_BITS-1:0]            feat_arr [FEAT_CNT];
   int unsigned                     lane_h [LANES];
   logic [LANES-1:0]                lane_valid, lane_hid;
   logic [INDEX_BITS-1:0]           pos_sum [LANES];
   logic [INDEX_BITS-1:0]           neg_sum [LANES];
   logic [SUM_BITS-1:0]             pop_add [CLASS_CNT];
   logic [PRED_BITS-1:0]            cls;
   logic [RAW_BITS-1:0]             score_raw;
   logic [SCORE_BITS-1:0]           score, cand_best;
   logic [PRED_BITS-1:0]            cand_idx;

   always_comb begin
      for (int f = 0; f < int'(FEAT_CNT); f++) begin
         feat_arr[f] = feat_q[(FEAT_CNT - 1 - f) * FEAT_BITS +: FEAT_BITS];
      end
   end

   // Hidden neurons for the current step; lanes past HIDDEN_CNT are masked off.
   always_comb begin
      for (int l = 0; l < int'(LANES); l++) begin
         lane_h[l]     = 32'(cnt_q) * LANES + 32'(l);
         lane_valid[l] = (lane_h[l] < HIDDEN_CNT);
         pos_sum[l]    = '0;
         neg_sum[l]    = '0;
         for (int f = 0; f < int'(FEAT_CNT); f++) begin
            if (lane_valid[l] && W1_POS[W1_IW'(lane_h[l] * FEAT_CNT + 32'(f))]) begin
               pos_sum[l] = pos_sum[l] + INDEX_BITS'(feat_arr[f]);
            end
            if (lane_valid[l] && W1_NEG[W1_IW'(lane_h[l] * FEAT_CNT + 32'(f))]) begin
               neg_sum[l] = neg_sum[l] + INDEX_BITS'(feat_arr[f]);
            end
         end
         lane_hid[l] = lane_valid[l] && (pos_sum[l] >= neg_sum[l]) &&
                       !H_FORCE0[H_IW'(lane_h[l])];
      end
   end

   always_comb begin
      for (int c = 0; c < int'(CLASS_CNT); c++) begin
         pop_add[c] = '0;
         for (int l = 0; l < int'(LANES); l++) begin
            if (lane_valid[l]) begin
               if (W2_POS[W2_IW'(32'(c) * HIDDEN_CNT + lane_h[l])] && lane_hid[l]) begin
                  pop_add[c] = pop_add[c] + SUM_BITS'(1);
               end
               if (W2_NEG[W2_IW'(32'(c) * HIDDEN_CNT + lane_h[l])] && !lane_hid[l]) begin
                  pop_add[c] = pop_add[c] + SUM_BITS'(1);
               end
            end
         end
      end
   end

   // Score of the class under evaluation, saturated; strict compare keeps the lowest index on ties.
   always_comb begin
      cls       = cnt_q[PRED_BITS-1:0];
      score_raw = {1'b0, pop_q[cls], 1'b0} +
                  RAW_BITS'(BIAS[B_IW'(32'(cls) * SCORE_BITS) +: SCORE_BITS]);
      score     = score_raw[SCORE_BITS] ? '1 : score_raw[SCORE_BITS-1:0];
      cand_best = best_q;
      cand_idx  = idx_q;
`ifdef TNN_SEQ_MARGIN_EN
      cand_second = second_q;
      if (score > best_q) begin
         cand_best   = score;
         cand_idx    = cls;
         cand_second = best_q;
      end else if (score > second_q) begin
         cand_second = score;
      end
`else
      if (score > best_q) begin
         cand_best = score;
         cand_idx  = cls;
      end
`endif
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      feat_d      = feat_q;
      best_d      = best_q;
      idx_d       = idx_q;
      pred_d      = pred_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      for (int c = 0; c < int'(CLASS_CNT); c++) pop_d[c] = pop_q[c];
`ifdef TNN_SEQ_MARGIN_EN
      second_d = second_q;
      margin_d = margin_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (in_valid && in_ready_q) begin
               feat_d     = features;
               cnt_d      = '0;
               best_d     = '0;
               idx_d      = '0;
               in_ready_d = 1'b0;
               state_d    = StHidden;
               for (int c = 0; c < int'(CLASS_CNT); c++) pop_d[c] = '0;
`ifdef TNN_SEQ_MARGIN_EN
               second_d = '0;
`endif
            end
         end
         StHidden: begin
            for (int c = 0; c < int'(CLASS_CNT); c++) pop_d[c] = pop_q[c] + pop_add[c];
            if (cnt_q == CNT_BITS'(H_STEPS - 1)) begin
               cnt_d   = '0;
               state_d = StArgmax;
            end else begin
               cnt_d = cnt_q + CNT_BITS'(1);
            end
         end
         StArgmax: begin
            best_d = cand_best;
            idx_d  = cand_idx;
`ifdef TNN_SEQ_MARGIN_EN
            second_d = cand_second;
`endif
            if (cnt_q == CNT_BITS'(CLASS_CNT - 1)) begin
               pred_d      = cand_idx;
               out_valid_d = 1'b1;
               state_d     = StDone;
`ifdef TNN_SEQ_MARGIN_EN
               margin_d = cand_best - cand_second;
`endif
            end else begin
               cnt_d = cnt_q + CNT_BITS'(1);
            end
         end
         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         feat_q      <= '0;
         best_q      <= '0;
         idx_q       <= '0;
         pred_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         for (int c = 0; c < int'(CLASS_CNT); c++) pop_q[c] <= '0;
`ifdef TNN_SEQ_MARGIN_EN
         second_q <= '0;
         margin_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         feat_q      <= feat_d;
         best_q      <= best_d;
         idx_q       <= idx_d;
         pred_q      <= pred_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         for (int c = 0; c < int'(CLASS_CNT); c++) pop_q[c] <= pop_d[c];
`ifdef TNN_SEQ_MARGIN_EN
         second_q <= second_d;
         margin_q <= margin_d;
`endif
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign prediction = pred_q;
`ifdef TNN_SEQ_MARGIN_EN
   assign margin = margin_q;
`else
   assign margin = '0;
`endif

endmodule
